// File: rtl/vram_arbiter_pkg.sv
// Shared types and default widths for the VRAM arbiter and its CPU write buffer.
// The statistics counters in the top are built only with VRAM_STATS_EN defined.
package vram_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int MAX_WAIT_DEF   = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VGA  = 2'd1,
    GNT_CPU  = 2'd2
  } grant_t;

  typedef enum logic {
    NORMAL   = 1'b0,
    FORCE_WR = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/vram_arbiter_wr_fifo.sv
// CPU write buffer: head visible combinationally, push/pop take effect on the next edge.
// Push is refused while the registered count is full, even if the same cycle pops.
module wr_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wr_req_t          push_dat_i,
  input  logic             pop_i,
  output wr_req_t          head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  wr_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM shared by scanout reads (priority) and buffered CPU writes; read data returns
// one cycle after grant. Optional stat_* counters are built when VRAM_STATS_EN is defined.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  output logic              vga_miss,
  output logic              overflow,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_STATS_EN
  ,
  output logic [31:0]       stat_vga_rd,
  output logic [31:0]       stat_cpu_wr,
  output logic [31:0]       stat_forced
`endif
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT) + 1;

  arb_state_t        state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              vga_miss_q;
  logic              vga_rvalid_q;
  logic [DATA_W-1:0] rdata_hold_q;
  logic              overflow_q;

  grant_t            grant;
  wr_req_t           push_dat;
  wr_req_t           head_dat;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              starve;

  assign push_dat = '{addr: cpu_addr, data: cpu_wdata};

  wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_wr_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (cpu_we),
    .push_dat_i (push_dat),
    .pop_i      (grant == GNT_CPU),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign cpu_stall = (fifo_count == CNT_W'(FIFO_DEPTH));

  // Reset also masks the grant so the RAM port is quiet while reset is held.
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      grant = GNT_NONE;
    end else if (state_q == FORCE_WR) begin
      grant = fifo_empty ? GNT_NONE : GNT_CPU;
    end else if (vga_req) begin
      grant = GNT_VGA;
    end else if (!fifo_empty) begin
      grant = GNT_CPU;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      GNT_VGA: begin
        mem_en   = 1'b1;
        mem_addr = vga_addr;
      end
      GNT_CPU: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head_dat.addr;
        mem_wdata = head_dat.data;
      end
      default: ;
    endcase
  end

  assign starve = fifo_full && (grant == GNT_VGA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= NORMAL;
      wait_q     <= '0;
      vga_miss_q <= 1'b0;
    end else begin
      case (state_q)
        NORMAL: begin
          vga_miss_q <= 1'b0;
          if (starve) begin
            if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
              state_q <= FORCE_WR;
              wait_q  <= '0;
            end else begin
              wait_q <= wait_q + WAIT_W'(1);
            end
          end else begin
            wait_q <= '0;
          end
        end
        FORCE_WR: begin
          state_q    <= NORMAL;
          wait_q     <= '0;
          vga_miss_q <= vga_req;
        end
        default: begin
          state_q    <= NORMAL;
          wait_q     <= '0;
          vga_miss_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_rvalid_q <= 1'b0;
      rdata_hold_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      vga_rvalid_q <= (grant == GNT_VGA);
      if (vga_rvalid_q)        rdata_hold_q <= mem_rdata;
      if (cpu_we && cpu_stall) overflow_q   <= 1'b1;
    end
  end

  // RAM data is passed straight through on the return cycle, then held.
  assign vga_rdata  = vga_rvalid_q ? mem_rdata : rdata_hold_q;
  assign vga_rvalid = vga_rvalid_q;
  assign vga_miss   = vga_miss_q;
  assign overflow   = overflow_q;

`ifdef VRAM_STATS_EN
  logic [31:0] stat_vga_rd_q;
  logic [31:0] stat_cpu_wr_q;
  logic [31:0] stat_forced_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_vga_rd_q <= '0;
      stat_cpu_wr_q <= '0;
      stat_forced_q <= '0;
    end else begin
      if (grant == GNT_VGA)     stat_vga_rd_q <= stat_vga_rd_q + 32'd1;
      if (grant == GNT_CPU)     stat_cpu_wr_q <= stat_cpu_wr_q + 32'd1;
      if (state_q == FORCE_WR)  stat_forced_q <= stat_forced_q + 32'd1;
    end
  end

  assign stat_vga_rd = stat_vga_rd_q;
  assign stat_cpu_wr = stat_cpu_wr_q;
  assign stat_forced = stat_forced_q;
`endif

endmodule
